// File: rtl/cpu_accel_hub_pkg.sv
// Constants shared by the accelerator hub, its FIFOs and the CPU register file.
// Also hosts the accel_id range check used by the hub decode.
package cpu_accel_hub_pkg;

    localparam int REG_WIDTH_DEF      = 16;
    localparam int ACCEL_ID_WIDTH_DEF = 4;
    localparam int ACCEL_COUNT_DEF    = 4;
    localparam int FIFO_DEPTH_DEF     = 4;

    // True when the CPU-supplied id addresses an attached accelerator.
    function automatic logic id_in_range(input logic [31:0] id, input logic [31:0] count);
        return (id < count);
    endfunction

endpackage

// File: rtl/cpu_accel_fifo.sv
// Flop-based synchronous FIFO with show-ahead read data and extra-MSB pointers.
// Full and empty come from registered pointers only, so a push is never bypassed by a same-cycle pop.
module cpu_accel_fifo
    import cpu_accel_hub_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; each pointer wraps naturally through its extra MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage, cleared on reset so no stale word survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/cpu_accel_hub.sv
// Routes the CPU's single accelerator port to ACCEL_COUNT accelerators through per-accelerator
// command and response FIFOs; out-of-range ids read as always ready so the CPU cannot deadlock.
module cpu_accel_hub
    import cpu_accel_hub_pkg::*;
#(
    parameter int REG_WIDTH      = REG_WIDTH_DEF,
    parameter int ACCEL_ID_WIDTH = ACCEL_ID_WIDTH_DEF,
    parameter int ACCEL_COUNT    = ACCEL_COUNT_DEF,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ACCEL_ID_WIDTH-1:0]        accel_id,
    output logic                             accel_can_read,
    output logic                             accel_can_write,
    input  logic                             accel_read_enable,
    output logic [REG_WIDTH-1:0]             accel_read_data,
    input  logic                             accel_write_enable,
    input  logic [REG_WIDTH-1:0]             accel_write_data,
    output logic [ACCEL_COUNT-1:0]           cmd_valid,
    output logic [ACCEL_COUNT*REG_WIDTH-1:0] cmd_data,
    input  logic [ACCEL_COUNT-1:0]           cmd_ready,
    input  logic [ACCEL_COUNT-1:0]           rsp_valid,
    input  logic [ACCEL_COUNT*REG_WIDTH-1:0] rsp_data,
    output logic [ACCEL_COUNT-1:0]           rsp_ready,
    output logic                             bad_id
);

    logic                             id_valid_s;
    logic [ACCEL_COUNT-1:0]           sel_s;
    logic [ACCEL_COUNT-1:0]           cmd_full_s;
    logic [ACCEL_COUNT-1:0]           cmd_empty_s;
    logic [ACCEL_COUNT-1:0]           rsp_full_s;
    logic [ACCEL_COUNT-1:0]           rsp_empty_s;
    logic [ACCEL_COUNT*REG_WIDTH-1:0] rsp_head_s;
    logic                             can_read_s;
    logic                             can_write_s;
    logic [REG_WIDTH-1:0]             read_data_s;
    logic                             bad_id_r;

    assign id_valid_s = id_in_range(32'(accel_id), 32'(ACCEL_COUNT));

    for (genvar i = 0; i < ACCEL_COUNT; i++) begin : g_accel
        assign sel_s[i] = id_valid_s && (32'(accel_id) == i);

        cpu_accel_fifo #(.WIDTH(REG_WIDTH), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (accel_write_enable && sel_s[i]),
            .push_data (accel_write_data),
            .pop       (cmd_ready[i]),
            .pop_data  (cmd_data[i*REG_WIDTH +: REG_WIDTH]),
            .full      (cmd_full_s[i]),
            .empty     (cmd_empty_s[i])
        );

        cpu_accel_fifo #(.WIDTH(REG_WIDTH), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (rsp_valid[i]),
            .push_data (rsp_data[i*REG_WIDTH +: REG_WIDTH]),
            .pop       (accel_read_enable && sel_s[i]),
            .pop_data  (rsp_head_s[i*REG_WIDTH +: REG_WIDTH]),
            .full      (rsp_full_s[i]),
            .empty     (rsp_empty_s[i])
        );

        assign cmd_valid[i] = !cmd_empty_s[i];
        assign rsp_ready[i] = !rsp_full_s[i];
    end

    // Status and read-data mux; an invalid id selects nothing and falls back to ready/zero.
    always_comb begin
        can_write_s = !id_valid_s;
        can_read_s  = !id_valid_s;
        read_data_s = {REG_WIDTH{1'b0}};
        for (int i = 0; i < ACCEL_COUNT; i++) begin
            can_write_s = can_write_s | (sel_s[i] & !cmd_full_s[i]);
            can_read_s  = can_read_s | (sel_s[i] & !rsp_empty_s[i]);
            read_data_s = read_data_s |
                          (sel_s[i] ? rsp_head_s[i*REG_WIDTH +: REG_WIDTH] : {REG_WIDTH{1'b0}});
        end
    end

    // Sticky flag for any CPU access to an unattached accelerator id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bad_id_r <= 1'b0;
        end else if (!id_valid_s && (accel_read_enable || accel_write_enable)) begin
            bad_id_r <= 1'b1;
        end
    end

    assign accel_can_write = can_write_s;
    assign accel_can_read  = can_read_s;
    assign accel_read_data = read_data_s;
    assign bad_id          = bad_id_r;

endmodule

// File: tb/tb_cpu_accel_hub.sv
// Directed bench for cpu_accel_hub: command/response ordering, full/empty gating,
// invalid-id handling and asynchronous reset, with hand-computed expectations.
module tb_cpu_accel_hub;

    localparam int RW = 16;
    localparam int IW = 4;
    localparam int AC = 4;

    logic             clk;
    logic             rst_n;
    logic [IW-1:0]    accel_id;
    logic             accel_can_read;
    logic             accel_can_write;
    logic             accel_read_enable;
    logic [RW-1:0]    accel_read_data;
    logic             accel_write_enable;
    logic [RW-1:0]    accel_write_data;
    logic [AC-1:0]    cmd_valid;
    logic [AC*RW-1:0] cmd_data;
    logic [AC-1:0]    cmd_ready;
    logic [AC-1:0]    rsp_valid;
    logic [AC*RW-1:0] rsp_data;
    logic [AC-1:0]    rsp_ready;
    logic             bad_id;

    int check_cnt;
    int fail_cnt;

    cpu_accel_hub #(.REG_WIDTH(RW), .ACCEL_ID_WIDTH(IW), .ACCEL_COUNT(AC), .FIFO_DEPTH(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .accel_id           (accel_id),
        .accel_can_read     (accel_can_read),
        .accel_can_write    (accel_can_write),
        .accel_read_enable  (accel_read_enable),
        .accel_read_data    (accel_read_data),
        .accel_write_enable (accel_write_enable),
        .accel_write_data   (accel_write_data),
        .cmd_valid          (cmd_valid),
        .cmd_data           (cmd_data),
        .cmd_ready          (cmd_ready),
        .rsp_valid          (rsp_valid),
        .rsp_data           (rsp_data),
        .rsp_ready          (rsp_ready),
        .bad_id             (bad_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] cmd_word(input int i);
        return cmd_data[i*RW +: RW];
    endfunction

    initial begin
        check_cnt          = 0;
        fail_cnt           = 0;
        rst_n              = 1'b0;
        accel_id           = 4'd0;
        accel_read_enable  = 1'b0;
        accel_write_enable = 1'b0;
        accel_write_data   = 16'h0000;
        cmd_ready          = 4'b0000;
        rsp_valid          = 4'b0000;
        rsp_data           = {(AC*RW){1'b0}};
        repeat (2) tick();
        rst_n = 1'b1;
        #1;

        check_eq("rst_can_write", 32'(accel_can_write), 32'd1);
        check_eq("rst_can_read", 32'(accel_can_read), 32'd0);
        check_eq("rst_cmd_valid", 32'(cmd_valid), 32'h0);
        check_eq("rst_rsp_ready", 32'(rsp_ready), 32'hF);
        check_eq("rst_bad_id", 32'(bad_id), 32'd0);

        // Two commands to accelerator 1, held off then delivered in order.
        accel_id           = 4'd1;
        accel_write_enable = 1'b1;
        accel_write_data   = 16'h1234;
        tick();
        accel_write_data   = 16'h5678;
        tick();
        accel_write_enable = 1'b0;
        #1;
        check_eq("c1_valid", 32'(cmd_valid), 32'b0010);
        check_eq("c1_head0", 32'(cmd_word(1)), 32'h1234);
        cmd_ready = 4'b0010;
        tick();
        check_eq("c1_head1", 32'(cmd_word(1)), 32'h5678);
        check_eq("c1_valid1", 32'(cmd_valid), 32'b0010);
        tick();
        check_eq("c1_drained", 32'(cmd_valid), 32'b0000);
        cmd_ready = 4'b0000;

        // Fill accelerator 2, overflow attempt, then pop+push while full.
        accel_id           = 4'd2;
        accel_write_enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            accel_write_data = 16'hA000 + 16'(k);
            tick();
        end
        accel_write_enable = 1'b0;
        #1;
        check_eq("c2_full", 32'(accel_can_write), 32'd0);
        accel_write_enable = 1'b1;
        accel_write_data   = 16'hDEAD;
        tick();
        accel_write_enable = 1'b0;
        #1;
        check_eq("c2_still_full", 32'(accel_can_write), 32'd0);
        check_eq("c2_head", 32'(cmd_word(2)), 32'hA000);
        cmd_ready          = 4'b0100;
        accel_write_enable = 1'b1;
        accel_write_data   = 16'hBEEF;
        tick();
        cmd_ready          = 4'b0000;
        accel_write_enable = 1'b0;
        #1;
        check_eq("c2_popfull_cw", 32'(accel_can_write), 32'd1);
        cmd_ready = 4'b0100;
        for (int k = 1; k < 4; k++) begin
            check_eq("c2_order", 32'(cmd_word(2)), 32'hA000 + 32'(k));
            tick();
        end
        check_eq("c2_no_extra", 32'(cmd_valid), 32'b0000);
        cmd_ready = 4'b0000;

        // Responses: accelerator 3 selected, accelerator 0 pushes unselected.
        accel_id                = 4'd3;
        rsp_valid               = 4'b1001;
        rsp_data[3*RW +: RW]    = 16'hBEEF;
        rsp_data[0*RW +: RW]    = 16'h0A0A;
        #1;
        check_eq("r3_no_fallthru", 32'(accel_can_read), 32'd0);
        tick();
        rsp_valid = 4'b0000;
        #1;
        check_eq("r3_can_read", 32'(accel_can_read), 32'd1);
        check_eq("r3_data", 32'(accel_read_data), 32'hBEEF);
        accel_read_enable = 1'b1;
        tick();
        accel_read_enable = 1'b0;
        #1;
        check_eq("r3_empty", 32'(accel_can_read), 32'd0);
        rsp_valid            = 4'b1000;
        rsp_data[3*RW +: RW] = 16'h1111;
        tick();
        rsp_data[3*RW +: RW] = 16'h2222;
        accel_read_enable    = 1'b1;
        tick();
        rsp_valid         = 4'b0000;
        accel_read_enable = 1'b0;
        #1;
        check_eq("r3_pp_can_read", 32'(accel_can_read), 32'd1);
        check_eq("r3_pp_data", 32'(accel_read_data), 32'h2222);
        accel_read_enable = 1'b1;
        tick();
        accel_read_enable = 1'b0;
        #1;
        check_eq("r3_pp_occ1", 32'(accel_can_read), 32'd0);
        rsp_valid = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            rsp_data[3*RW +: RW] = 16'h3000 + 16'(k);
            tick();
        end
        rsp_valid = 4'b0000;
        #1;
        check_eq("r3_rsp_ready_full", 32'(rsp_ready), 32'b0111);
        accel_id = 4'd0;
        #1;
        check_eq("r0_unsel_can_read", 32'(accel_can_read), 32'd1);
        check_eq("r0_unsel_data", 32'(accel_read_data), 32'h0A0A);

        // Invalid id.
        accel_id           = 4'd5;
        accel_write_enable = 1'b1;
        accel_write_data   = 16'h9999;
        #1;
        check_eq("bad_can_write", 32'(accel_can_write), 32'd1);
        check_eq("bad_can_read", 32'(accel_can_read), 32'd1);
        check_eq("bad_read_data", 32'(accel_read_data), 32'h0);
        check_eq("bad_id_before", 32'(bad_id), 32'd0);
        tick();
        accel_write_enable = 1'b0;
        #1;
        check_eq("bad_id_set", 32'(bad_id), 32'd1);
        check_eq("bad_cmd_valid", 32'(cmd_valid), 32'b0000);
        check_eq("bad_rsp_ready", 32'(rsp_ready), 32'b0111);
        repeat (3) tick();
        check_eq("bad_id_held", 32'(bad_id), 32'd1);

        // Asynchronous reset with accelerator 0 holding three commands.
        accel_id           = 4'd0;
        accel_write_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            accel_write_data = 16'hC000 + 16'(k);
            tick();
        end
        accel_write_enable = 1'b0;
        #1;
        check_eq("ar_pre_valid", 32'(cmd_valid), 32'b0001);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("ar_cmd_valid", 32'(cmd_valid), 32'b0000);
        check_eq("ar_bad_id", 32'(bad_id), 32'd0);
        check_eq("ar_rsp_ready", 32'(rsp_ready), 32'hF);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("ar_can_write", 32'(accel_can_write), 32'd1);
        check_eq("ar_can_read", 32'(accel_can_read), 32'd0);
        accel_write_enable = 1'b1;
        accel_write_data   = 16'hC0DE;
        tick();
        accel_write_enable = 1'b0;
        #1;
        check_eq("ar_fresh_data", 32'(cmd_word(0)), 32'hC0DE);
        cmd_ready = 4'b0001;
        tick();
        check_eq("ar_no_stale", 32'(cmd_valid), 32'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
